// File: rtl/cfg_axi_pkg.sv
// Shared definitions for the cfg-bus to AXI-lite bridge.
//   cfg_axi_state_e : bridge FSM state encoding (3 bits)
//   AXI_RESP_OKAY   : AXI response code for a successful transfer
//   AXI_WSTRB_ALL   : write strobe with all byte lanes enabled
package cfg_axi_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_RESP = 3'd4
    } cfg_axi_state_e;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
    localparam logic [3:0] AXI_WSTRB_ALL = 4'hF;

endpackage

// File: rtl/cfg_conv_axi.sv
// cfg_conv_axi: converts single-beat cfg-bus read/write requests into
// AXI-lite master transactions, one at a time.
// Ports:
//   i_axi_clk, i_axi_rst_n      : clock, synchronous active-low reset
//   s_cfg_*                     : cfg slave (wr_en/rd_en requests, addr, data,
//                                 rd_vld strobe, rd_data, busy)
//   m_axi_aw*/w*/b*/ar*/r*      : AXI-lite master channels
//   o_resp_err, o_err_cnt       : sticky error flag and saturating error count,
//                                 present only with CFG_CONV_AXI_RESP_ERR_EN
module cfg_conv_axi
    import cfg_axi_pkg::*;
#(
    parameter int unsigned CFG_DATA_WIDTH = 32,
    parameter int unsigned CFG_ADDR_WIDTH = 32,
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 32
) (
    input  logic                      i_axi_clk,
    input  logic                      i_axi_rst_n,
    input  logic                      s_cfg_wr_en,
    input  logic [CFG_DATA_WIDTH-1:0] s_cfg_wr_data,
    input  logic [CFG_ADDR_WIDTH-1:0] s_cfg_addr,
    input  logic                      s_cfg_rd_en,
    output logic                      s_cfg_rd_vld,
    output logic [CFG_DATA_WIDTH-1:0] s_cfg_rd_data,
    output logic                      s_cfg_busy,
`ifdef CFG_CONV_AXI_RESP_ERR_EN
    output logic                      o_resp_err,
    output logic [7:0]                o_err_cnt,
`endif
    output logic [AXI_ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic                      m_axi_awvalid,
    input  logic                      m_axi_awready,
    output logic [AXI_DATA_WIDTH-1:0] m_axi_wdata,
    output logic [3:0]                m_axi_wstrb,
    output logic                      m_axi_wvalid,
    input  logic                      m_axi_wready,
    input  logic [1:0]                m_axi_bresp,
    input  logic                      m_axi_bvalid,
    output logic                      m_axi_bready,
    output logic [AXI_ADDR_WIDTH-1:0] m_axi_araddr,
    output logic                      m_axi_arvalid,
    input  logic                      m_axi_arready,
    input  logic [AXI_DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]                m_axi_rresp,
    input  logic                      m_axi_rvalid,
    output logic                      m_axi_rready
);

    cfg_axi_state_e              r_state, w_state_nxt;
    logic                        r_awvalid, w_awvalid_nxt;
    logic                        r_wvalid, w_wvalid_nxt;
    logic                        r_bready, w_bready_nxt;
    logic                        r_arvalid, w_arvalid_nxt;
    logic                        r_rready, w_rready_nxt;
    logic                        r_busy, w_busy_nxt;
    logic                        r_rd_vld, w_rd_vld_nxt;
    logic [CFG_DATA_WIDTH-1:0]   r_rd_data, w_rd_data_nxt;
    logic [AXI_ADDR_WIDTH-1:0]   r_addr, w_addr_nxt;
    logic [AXI_DATA_WIDTH-1:0]   r_wdata, w_wdata_nxt;
    logic                        w_aw_done, w_w_done;

    // State and registered outputs
    always_ff @(posedge i_axi_clk) begin
        if (!i_axi_rst_n) begin
            r_state   <= IDLE;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_bready  <= 1'b0;
            r_arvalid <= 1'b0;
            r_rready  <= 1'b0;
            r_busy    <= 1'b0;
            r_rd_vld  <= 1'b0;
            r_rd_data <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_awvalid <= w_awvalid_nxt;
            r_wvalid  <= w_wvalid_nxt;
            r_bready  <= w_bready_nxt;
            r_arvalid <= w_arvalid_nxt;
            r_rready  <= w_rready_nxt;
            r_busy    <= w_busy_nxt;
            r_rd_vld  <= w_rd_vld_nxt;
            r_rd_data <= w_rd_data_nxt;
            r_addr    <= w_addr_nxt;
            r_wdata   <= w_wdata_nxt;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt   = r_state;
        w_awvalid_nxt = r_awvalid;
        w_wvalid_nxt  = r_wvalid;
        w_bready_nxt  = r_bready;
        w_arvalid_nxt = r_arvalid;
        w_rready_nxt  = r_rready;
        w_rd_vld_nxt  = 1'b0;
        w_rd_data_nxt = r_rd_data;
        w_addr_nxt    = r_addr;
        w_wdata_nxt   = r_wdata;
        // A channel counts as done once its valid has dropped or handshakes now
        w_aw_done     = !r_awvalid || m_axi_awready;
        w_w_done      = !r_wvalid  || m_axi_wready;

        case (r_state)
            IDLE: begin
                if (s_cfg_wr_en) begin
                    w_state_nxt   = WR_REQ;
                    w_addr_nxt    = AXI_ADDR_WIDTH'(s_cfg_addr);
                    w_wdata_nxt   = AXI_DATA_WIDTH'(s_cfg_wr_data);
                    w_awvalid_nxt = 1'b1;
                    w_wvalid_nxt  = 1'b1;
                end else if (s_cfg_rd_en) begin
                    w_state_nxt   = RD_REQ;
                    w_addr_nxt    = AXI_ADDR_WIDTH'(s_cfg_addr);
                    w_arvalid_nxt = 1'b1;
                end
            end
            WR_REQ: begin
                if (r_awvalid && m_axi_awready) w_awvalid_nxt = 1'b0;
                if (r_wvalid  && m_axi_wready)  w_wvalid_nxt  = 1'b0;
                if (w_aw_done && w_w_done) begin
                    w_state_nxt  = WR_RESP;
                    w_bready_nxt = 1'b1;
                end
            end
            WR_RESP: begin
                if (m_axi_bvalid) begin
                    w_state_nxt  = IDLE;
                    w_bready_nxt = 1'b0;
                end
            end
            RD_REQ: begin
                if (m_axi_arready) begin
                    w_state_nxt   = RD_RESP;
                    w_arvalid_nxt = 1'b0;
                    w_rready_nxt  = 1'b1;
                end
            end
            RD_RESP: begin
                if (m_axi_rvalid) begin
                    w_state_nxt   = IDLE;
                    w_rready_nxt  = 1'b0;
                    w_rd_vld_nxt  = 1'b1;
                    w_rd_data_nxt = m_axi_rdata[CFG_DATA_WIDTH-1:0];
                end
            end
            default: begin
                w_state_nxt   = IDLE;
                w_awvalid_nxt = 1'b0;
                w_wvalid_nxt  = 1'b0;
                w_bready_nxt  = 1'b0;
                w_arvalid_nxt = 1'b0;
                w_rready_nxt  = 1'b0;
            end
        endcase

        w_busy_nxt = (w_state_nxt != IDLE);
    end

    assign s_cfg_rd_vld  = r_rd_vld;
    assign s_cfg_rd_data = r_rd_data;
    assign s_cfg_busy    = r_busy;
    assign m_axi_awaddr  = r_addr;
    assign m_axi_awvalid = r_awvalid;
    assign m_axi_wdata   = r_wdata;
    assign m_axi_wstrb   = AXI_WSTRB_ALL;
    assign m_axi_wvalid  = r_wvalid;
    assign m_axi_bready  = r_bready;
    assign m_axi_araddr  = r_addr;
    assign m_axi_arvalid = r_arvalid;
    assign m_axi_rready  = r_rready;

`ifdef CFG_CONV_AXI_RESP_ERR_EN
    logic       r_resp_err;
    logic [7:0] r_err_cnt;
    logic       w_err_evt;
    logic       w_unused_rdata;

    // Non-OKAY response on a completing B or R handshake
    assign w_err_evt = ((r_state == WR_RESP) && m_axi_bvalid && (m_axi_bresp != AXI_RESP_OKAY))
                    || ((r_state == RD_RESP) && m_axi_rvalid && (m_axi_rresp != AXI_RESP_OKAY));

    // Sticky flag and saturating counter
    always_ff @(posedge i_axi_clk) begin
        if (!i_axi_rst_n) begin
            r_resp_err <= 1'b0;
            r_err_cnt  <= 8'd0;
        end else if (w_err_evt) begin
            r_resp_err <= 1'b1;
            if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign o_resp_err     = r_resp_err;
    assign o_err_cnt      = r_err_cnt;
    assign w_unused_rdata = ^m_axi_rdata;
`else
    logic w_unused_resp;
    assign w_unused_resp = ^{m_axi_bresp, m_axi_rresp, m_axi_rdata};
`endif

endmodule

// File: doc/cfg_conv_axi.md
CFG_CONV_AXI -- requirements
Module: cfg_conv_axi

Interface
REQ-001 SHALL have parameter CFG_DATA_WIDTH, default 32: width of the cfg-bus data.
REQ-002 SHALL have parameter CFG_ADDR_WIDTH, default 32: width of the cfg-bus address.
REQ-003 SHALL have parameter AXI_ADDR_WIDTH, default 32: width of the AXI-lite address.
REQ-004 SHALL have parameter AXI_DATA_WIDTH, default 32: width of the AXI-lite data; CFG_DATA_WIDTH <= AXI_DATA_WIDTH.
REQ-005 SHALL have ports i_axi_clk (in, 1): the single clock; i_axi_rst_n (in, 1): reset, synchronous and active-low.
REQ-006 SHALL have cfg slave ports:
- s_cfg_wr_en (in, 1): write request.
- s_cfg_wr_data (in, CFG_DATA_WIDTH): write data.
- s_cfg_addr (in, CFG_ADDR_WIDTH): address.
- s_cfg_rd_en (in, 1): read request.
- s_cfg_rd_vld (out, 1): read-data strobe.
- s_cfg_rd_data (out, CFG_DATA_WIDTH): read data.
- s_cfg_busy (out, 1): transaction in progress.
REQ-007 SHALL have AXI-lite master ports:
- m_axi_awaddr (out, AXI_ADDR_WIDTH), m_axi_awvalid (out, 1), m_axi_awready (in, 1).
- m_axi_wdata (out, AXI_DATA_WIDTH), m_axi_wstrb (out, 4), m_axi_wvalid (out, 1), m_axi_wready (in, 1).
- m_axi_bresp (in, 2), m_axi_bvalid (in, 1), m_axi_bready (out, 1).
- m_axi_araddr (out, AXI_ADDR_WIDTH), m_axi_arvalid (out, 1), m_axi_arready (in, 1).
- m_axi_rdata (in, AXI_DATA_WIDTH), m_axi_rresp (in, 2), m_axi_rvalid (in, 1), m_axi_rready (out, 1).

Function
REQ-008 FSM states SHALL be IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP; s_cfg_busy SHALL be registered, 1 in every state except IDLE.
REQ-009 In IDLE, a request SHALL be accepted when its enable is 1 at the clock edge; the address is latched, and for writes the data is latched. The write request wins when wr_en and rd_en are asserted in the same cycle.
REQ-010 Write accept at cycle T SHALL enter WR_REQ and drive awvalid=wvalid=1 from T+1. Each valid SHALL drop independently after its own valid&ready; WR_RESP is entered once both handshakes are done.
REQ-011 WR_RESP SHALL drive bready=1 and return to IDLE on bvalid. Best case: aw/w ready at T+1, bvalid at T+2, busy=0 at T+3.
REQ-012 Read accept at T SHALL drive arvalid=1 from T+1 until arready. RD_RESP then drives rready=1; on rvalid, s_cfg_rd_data <= rdata[CFG_DATA_WIDTH-1:0], s_cfg_rd_vld pulses for exactly one cycle, and the FSM returns to IDLE in that same cycle.
REQ-013 s_cfg_rd_data SHALL hold its value until the next read completes.
REQ-014 Address SHALL be zero-extended or truncated to AXI_ADDR_WIDTH; write data SHALL be zero-extended to AXI_DATA_WIDTH; wstrb SHALL be 4'hF.
REQ-015 Requests arriving while busy=1 SHALL be ignored. The requester holds its enable until it sees busy=0, so the request is accepted in the first IDLE cycle.
REQ-016 Valid outputs SHALL NOT depend combinationally on ready inputs, and awaddr/wdata/araddr SHALL stay stable while the corresponding valid is high.
REQ-017 Without REQ-021, bresp/rresp SHALL be ignored.

Reset
REQ-018 On i_axi_rst_n=0 at a clock edge, the block SHALL go to IDLE and clear every valid, ready, busy and rd_vld output, s_cfg_rd_data, and the latched address/data to 0.
REQ-019 Reset mid-transaction SHALL abort the transaction with no response to the cfg side.
REQ-020 Reset SHALL take priority over every other event in the same cycle.

Configuration
REQ-021 With CFG_CONV_AXI_RESP_ERR_EN defined:
- Output o_resp_err (1) is present; it is set sticky on bresp!=0 or rresp!=0 and cleared only by reset.
- Output o_err_cnt (8) is present; it counts error responses and saturates at 255.
- Without the macro, neither port nor its logic exists.

Structure
REQ-022 The FSM enum (3-bit) and the AXI response constants (OKAY=2'b00) SHALL live in shared package cfg_axi_pkg.
REQ-023 There SHALL be no sub-module; the block is a single FSM plus its registers.

Verification
REQ-024 Write addr 0x10, data 0xA5A5_0001, with aw/w/b ready immediately: aw and w handshake at T+1, bready at T+2, busy 1→0 at T+3, wdata=0xA5A5_0001.
REQ-025 Write with awready at T+1 and wready delayed to T+4: awvalid drops at T+2, wvalid holds until T+4, then bvalid completes the transaction.
REQ-026 Read addr 0x20 with rvalid and rdata=0x1234_5678 three cycles after arready: rd_vld is a single-cycle pulse and rd_data=0x1234_5678.
REQ-027 wr_en and rd_en high in the same cycle: only the write is issued (arvalid stays 0); rd_en held high gives a read accepted in the first idle cycle after the write.
REQ-028 Reset asserted while in WR_REQ with awvalid=1: the next cycle shows all valids 0, busy 0, and the FSM in IDLE.
REQ-029 With CFG_CONV_AXI_RESP_ERR_EN defined, rresp=2'b10 on a read: o_resp_err=1, o_err_cnt=1, and rd_vld still pulses.
